// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds the cache geometry, the derived address-field widths, the controller
// state type and helpers that split a byte address into word/index/tag fields.
// Geometry is set here so every file agrees on the field widths.
package cache_pkg;

  localparam int unsigned NUM_LINES      = 16;  // power of 2
  localparam int unsigned WORDS_PER_LINE = 4;   // power of 2, also refill beat count
  localparam int unsigned ADDR_WIDTH     = 32;

  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned WORD_W   = $clog2(WORDS_PER_LINE);
  localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W    = ADDR_WIDTH - INDEX_W - WORD_W - OFFSET_W;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_WIDTH-1:0] addr);
    return addr[OFFSET_W +: WORD_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    return addr[OFFSET_W + WORD_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/cache_data_array.sv
// Valid/tag/data storage for the data cache.
// Ports:
//   clock, reset           - system clock, synchronous active-high reset (clears valid only)
//   rd_index, rd_word      - combinational read address
//   rd_valid/rd_tag/rd_data - line valid bit, line tag and selected word
//   wr_en, wr_index, wr_word, wr_be, wr_data - byte-enabled word write
//   wr_set_valid, wr_tag   - mark wr_index valid and load its tag
module cache_data_array
  import cache_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [WORD_W-1:0]  rd_word,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [3:0]         wr_be,
  input  logic [31:0]        wr_data,
  input  logic               wr_set_valid,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_set_valid) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tags and data are never cleared; valid alone gates their use.
  always_ff @(posedge clock) begin
    if (wr_set_valid) begin
      tag_q[wr_index] <= wr_tag;
    end
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          data_q[wr_index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   cpu_*        - MEM-stage load/store request; cpu_stall freezes the pipeline,
//                  cpu_rdata is the load word when a load is not stalled
//   mem_*        - word-wide backing memory port; a beat completes on mem_ready
module data_cache
  import cache_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_sb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_e             state_q;
  logic [WORD_W-1:0]  beat_q;
  logic [TAG_W-1:0]   miss_tag_q;
  logic [INDEX_W-1:0] miss_index_q;
  logic [31:0]        st_addr_q;
  logic [31:0]        st_data_q;
  logic               st_sb_q;
  logic               st_hit_q;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               hit;
  logic               last_beat;
  logic [3:0]         store_be;
  logic [31:0]        store_wdata;

  logic               refill_beat;
  logic               store_update;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [WORD_W-1:0]  wr_word;
  logic [3:0]         wr_be;
  logic [31:0]        wr_data;
  logic               wr_set_valid;

  assign hit       = rd_valid && (rd_tag == addr_tag(cpu_addr));
  assign last_beat = (beat_q == WORD_W'(WORDS_PER_LINE - 1));
  assign cpu_rdata = rd_data;

  assign store_be    = st_sb_q ? (4'b0001 << st_addr_q[1:0]) : 4'b1111;
  assign store_wdata = st_sb_q ? {4{st_data_q[7:0]}} : st_data_q;

  // Array writes: each refill beat, and the write-through beat of a store that hit.
  assign refill_beat  = (state_q == StRefill) && mem_ready && !reset;
  assign store_update = (state_q == StWrite) && mem_ready && st_hit_q && !reset;
  assign wr_en        = refill_beat || store_update;
  assign wr_index     = (state_q == StRefill) ? miss_index_q : addr_index(st_addr_q);
  assign wr_word      = (state_q == StRefill) ? beat_q : addr_word(st_addr_q);
  assign wr_be        = (state_q == StRefill) ? 4'b1111 : store_be;
  assign wr_data      = (state_q == StRefill) ? mem_rdata : store_wdata;
  // Valid is only raised on the final beat, so an abandoned refill never leaves a valid line.
  assign wr_set_valid = refill_beat && last_beat;

  cache_data_array u_array (
    .clock        (clock),
    .reset        (reset),
    .rd_index     (addr_index(cpu_addr)),
    .rd_word      (addr_word(cpu_addr)),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_index     (wr_index),
    .wr_word      (wr_word),
    .wr_be        (wr_be),
    .wr_data      (wr_data),
    .wr_set_valid (wr_set_valid),
    .wr_tag       (miss_tag_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_req) begin
            if (cpu_we) begin
              st_addr_q <= cpu_addr;
              st_data_q <= cpu_wdata;
              st_sb_q   <= cpu_sb;
              st_hit_q  <= hit;
              state_q   <= StWrite;
            end else if (!hit) begin
              miss_tag_q   <= addr_tag(cpu_addr);
              miss_index_q <= addr_index(cpu_addr);
              beat_q       <= '0;
              state_q      <= StRefill;
            end
          end
        end
        StRefill: begin
          if (mem_ready) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              state_q <= StIdle;
            end
          end
        end
        StWrite: begin
          if (mem_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory drive comes straight from latched state, so it stays stable until mem_ready.
  always_comb begin
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b1111;
    if (!reset) begin
      unique case (state_q)
        StIdle: cpu_stall = cpu_req && (cpu_we || !hit);
        StRefill: begin
          cpu_stall = 1'b1;
          mem_req   = 1'b1;
          mem_addr  = {miss_tag_q, miss_index_q, beat_q, 2'b00};
        end
        StWrite: begin
          // Dropping stall in the ready cycle retires the store exactly once.
          cpu_stall = !mem_ready;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {st_addr_q[31:2], 2'b00};
          mem_be    = store_be;
          mem_wdata = store_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_sb;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  data_cache dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_sb    (cpu_sb),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_op_t;

  mem_op_t     mem_q[$];
  logic [31:0] load_q[$];
  int          total = 0;
  int          bad = 0;
  int          beats_done = 0;
  int          delay_lo = 0;
  int          delay_hi = 0;
  bit          spurious = 1'b0;
  logic [31:0] last_rdata;

  logic [31:0] bmem [int unsigned];  // backing memory as seen by the responder
  logic [31:0] rmem [int unsigned];  // reference memory image
  bit          mval [16];
  logic [23:0] mtag [16];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a >> 2) + 32'h0000_0FF0;  // word at 0x40 + 4k holds 0x1000 + k
  endfunction

  function automatic logic [31:0] bread(input logic [31:0] a);
    if (bmem.exists(a >> 2)) return bmem[a >> 2];
    return init_word(a);
  endfunction

  function automatic logic [31:0] rread(input logic [31:0] a);
    if (rmem.exists(a >> 2)) return rmem[a >> 2];
    return init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: wait a random number of cycles per beat, then complete it.
  int wait_left = -1;
  always @(posedge clock) begin
    logic [31:0] w;
    #2;
    if (mem_req) begin
      if (wait_left < 0) wait_left = $urandom_range(delay_hi, delay_lo);
      if (wait_left == 0) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          w = bread(mem_addr);
          for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
          bmem[mem_addr >> 2] = w;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = bread(mem_addr);
        end
        wait_left = -1;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      wait_left = -1;
      mem_ready = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
      mem_rdata = $urandom;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a beat or returns a load.
  always @(negedge clock) begin
    mem_op_t e;
    logic [31:0] exp_rd;
    if (reset) begin
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset cpu_stall", 32'(cpu_stall), 32'd0);
    end else begin
      if (mem_req && mem_ready) begin
        beats_done++;
        if (mem_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected mem beat: got addr %h we %0d, expected none", mem_addr, mem_we);
        end else begin
          e = mem_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", mem_addr, e.addr);
          check("mem_be", 32'(mem_be), 32'(e.be));
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (cpu_req && !cpu_we && !cpu_stall) begin
        if (load_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected load response: got %h, expected none", cpu_rdata);
        end else begin
          exp_rd = load_q.pop_front();
          check("load rdata", cpu_rdata, exp_rd);
        end
      end
    end
  end

  // Push the expected response of one request from the reference model.
  task automatic expect_op(input bit we, input bit sb, input logic [31:0] addr,
                           input logic [31:0] data);
    mem_op_t     op;
    logic [31:0] w;
    int          idx, off;
    logic [23:0] tag;
    idx = int'((addr >> 4) % 16);
    tag = addr[31:8];
    off = int'(addr % 4);
    if (we) begin
      op.we    = 1'b1;
      op.addr  = addr & 32'hFFFF_FFFC;
      w = rread(addr);
      if (sb) begin
        op.be    = 4'(1 << off);
        op.wdata = {4{data[7:0]}};
        w[8*off +: 8] = data[7:0];
      end else begin
        op.be    = 4'hF;
        op.wdata = data;
        w = data;
      end
      rmem[addr >> 2] = w;
      mem_q.push_back(op);
    end else begin
      if (!(mval[idx] && mtag[idx] == tag)) begin
        for (int k = 0; k < 4; k++) begin
          op.we    = 1'b0;
          op.addr  = (addr & 32'hFFFF_FFF0) + 32'(4 * k);
          op.be    = 4'hF;
          op.wdata = '0;
          mem_q.push_back(op);
        end
        mval[idx] = 1'b1;
        mtag[idx] = tag;
      end
      load_q.push_back(rread(addr));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the request retires.
  task automatic issue(input bit we, input bit sb, input logic [31:0] addr,
                       input logic [31:0] data, output int stalls);
    expect_op(we, sb, addr, data);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_sb    = sb;
    cpu_addr  = addr;
    cpu_wdata = data;
    stalls = 0;
    @(negedge clock);
    while (cpu_stall && stalls < 300) begin
      stalls++;
      @(negedge clock);
    end
    if (cpu_stall) begin
      total++;
      bad++;
      $display("FAIL request timeout: addr %h still stalled, expected retire", addr);
    end
    last_rdata = cpu_rdata;
    @(posedge clock);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    cpu_sb  = 1'b0;
    check("mem queue drained", 32'(mem_q.size()), 32'd0);
    check("load queue drained", 32'(load_q.size()), 32'd0);
  endtask

  initial begin
    int st, n;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_sb = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 16; i++) mval[i] = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("idle cpu_stall", 32'(cpu_stall), 32'd0);
    check("idle mem_req", 32'(mem_req), 32'd0);
    @(posedge clock);
    #1;

    issue(1'b0, 1'b0, 32'h40, '0, st);
    check("cold miss stall cycles", 32'(st), 32'd5);
    check("cold miss rdata", last_rdata, 32'h0000_1000);
    issue(1'b0, 1'b0, 32'h48, '0, st);
    check("hit stall cycles", 32'(st), 32'd0);
    check("hit rdata", last_rdata, 32'h0000_1002);
    issue(1'b1, 1'b1, 32'h45, 32'h0000_00AB, st);
    check("sb stall cycles", 32'(st), 32'd1);
    issue(1'b0, 1'b0, 32'h44, '0, st);
    check("load after sb stall", 32'(st), 32'd0);
    check("load after sb rdata", last_rdata, 32'h0000_AB01);

    delay_lo = 2; delay_hi = 2;
    issue(1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, st);
    check("store miss stall cycles", 32'(st), 32'd3);
    delay_lo = 0; delay_hi = 0;
    issue(1'b0, 1'b0, 32'h200, '0, st);
    check("load after store miss stall", 32'(st), 32'd5);
    check("load after store miss rdata", last_rdata, 32'hDEAD_BEEF);

    issue(1'b0, 1'b0, 32'h140, '0, st);
    check("conflict load stall", 32'(st), 32'd5);
    issue(1'b0, 1'b0, 32'h40, '0, st);
    check("evicted reload stall", 32'(st), 32'd5);

    // Reset two beats into a slow refill.
    delay_lo = 3; delay_hi = 3;
    beats_done = 0;
    expect_op(1'b0, 1'b0, 32'h340, '0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_sb = 1'b0; cpu_addr = 32'h340;
    n = 0;
    while (beats_done < 2 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (beats_done < 2) begin
      total++;
      bad++;
      $display("FAIL refill beats timeout: got %0d beats, expected 2", beats_done);
    end
    #1;
    reset = 1'b1;
    cpu_req = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_q.delete();
    load_q.delete();
    for (int i = 0; i < 16; i++) mval[i] = 1'b0;
    issue(1'b0, 1'b0, 32'h340, '0, st);
    check("post-reset refill stall", 32'(st), 32'd17);
    check("post-reset refill rdata", last_rdata, init_word(32'h340));

    // Random traffic over a few conflicting lines.
    delay_lo = 0; delay_hi = 2;
    spurious = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      bit          w;
      a = (32'($urandom_range(3, 0)) << 8) | (32'($urandom_range(3, 0)) << 4) |
          (32'($urandom_range(3, 0)) << 2) | 32'($urandom_range(3, 0));
      w = ($urandom_range(2, 0) == 0);
      issue(w, 1'($urandom_range(1, 0)), a, $urandom, st);
      repeat ($urandom_range(2, 0)) @(posedge clock);
      #0;
    end

    check("final mem queue", 32'(mem_q.size()), 32'd0);
    check("final load queue", 32'(load_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
